bpu_btb: RTL
============

Name: bpu_btb

Overview:
- Parametrised successor to the core's single-shot branch predictor.
- Adds three things:
  - a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters;
  - a commit-time return address stack (RAS);
  - a sequential invalidate sweep.
- Lookup is combinational on the fetch PC and feeds pc_reg/if_id.
- Training comes from the ex stage with resolved branch outcomes, one update per cycle.

Parameters:
- ADDR_W, 32: instruction address width.
- ENTRIES, 16: BTB entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- TAG_W, 8: stored tag bits. Requires TAG_W+IDX_W+2 ≤ ADDR_W.
- RAS_DEPTH, 4: return stack entries; power of two, ≥2.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: asynchronous, active-low.
- pred_pc_i  in  ADDR_W  fetch address to predict.
- pred_hit_o  out  1  valid BTB entry matches pred_pc_i.
- pred_taken_o  out  1  predict redirect.
- pred_target_o  out  ADDR_W  predicted target.
- upd_valid_i  in  1  resolved control-flow instruction from ex.
- upd_pc_i  in  ADDR_W  its address.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  ADDR_W  actual target.
- upd_type_i  in  2  instruction type: 0 = cond branch, 1 = jal/jalr, 2 = call, 3 = ret.
- flush_i  in  1  start invalidate sweep (fence.i / jtag reset).
- busy_o  out  1  sweep in progress.

Behaviour:
- Addressing:
  - index = pc[IDX_W+1:2]
  - tag = pc[TAG_W+IDX_W+1:IDX_W+2]
  - Entry state: valid, tag, type, target, ctr[1:0].
- Reset (rst low, async):
  - all valid=0, all ctr=2'b01, RAS count=0 and top pointer=0, FSM=IDLE, sweep index=0.
  - Outputs are therefore 0: pred_hit_o=0, pred_taken_o=0, pred_target_o=0, busy_o=0.
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - taken = hit && (type≠0 || ctr[1]).
  - target = RAS top when type==3 and RAS count≠0; otherwise the stored target.
  - When hit=0, target=0.
- Update (registered on clk edge, when upd_valid_i && FSM==IDLE):
  - On hit, counter training:
    - taken: ctr saturates up at 3;
    - not taken: ctr saturates down at 0.
    - target, type overwritten.
  - On miss with upd_taken_i=1 or type≠0: allocate (overwrite slot) with valid=1, new tag, type, target, ctr=2'b10.
  - On miss with a not-taken cond branch: no allocation.
- RAS (commit-time):
  - call: push upd_pc_i+4. When full, overwrite oldest; circular pointer, count saturates at RAS_DEPTH.
  - ret: pop. When empty, no change, count stays 0.
  - Wrap of pointer is modulo RAS_DEPTH.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents.
- Sweep FSM:
  - IDLE→SWEEP on flush_i. RAS cleared on that edge. Index counter starts at 0.
  - SWEEP: clears valid[idx] each cycle, idx++. After idx==ENTRIES-1 → IDLE.
  - Sweep takes exactly ENTRIES cycles.
  - During SWEEP:
    - busy_o=1;
    - pred_hit_o/pred_taken_o forced 0;
    - updates dropped.
  - flush_i during SWEEP restarts idx at 0.
  - rst low mid-sweep → IDLE immediately.

Decomposition:
- Shared package/defines:
  - upd_type encodings (BP_BRANCH/BP_JAL/BP_CALL/BP_RET);
  - counter constants (CTR_WNT=2'b01, CTR_WT=2'b10);
  - FSM state encodings.
- One natural sub-module: bpu_ras (circular push/pop stack with saturating count, parameter RAS_DEPTH).
- Table and FSM stay in bpu_btb.

Test Plan:
1. Reset then lookup 0x100 → hit=0, taken=0, target=0, busy=0.
2. Counter training on cond branch 0x100, target 0x180:
   - update taken once → lookup hit=1, taken=1, target=0x180 (ctr=2);
   - two not-taken updates → taken=0 (ctr=0);
   - four taken updates → ctr saturates 3, one not-taken → still taken.
3. Aliasing (ENTRIES=16): allocate 0x100; update 0x140 (same index, different tag) taken to 0x200 → lookup 0x100 hit=0, lookup 0x140 target=0x200.
4. RAS with RAS_DEPTH=4:
   - calls at 0x10, 0x20, 0x30, 0x40, 0x50, then ret at 0x300 allocated → target 0x54;
   - four more rets → targets 0x44, 0x34, 0x24;
   - then stored target fallback once empty.
5. Flush sweep:
   - after populating entries, pulse flush_i → busy_o high exactly 16 cycles, predictions 0 throughout;
   - update issued mid-sweep is ignored;
   - all lookups miss afterwards.
6. Same-cycle update and lookup on 0x100: lookup shows old entry, next cycle new.
7. Reset asserted mid-sweep: busy_o drops asynchronously and the table is empty.

Source files
------------

// File: rtl/bpu_btb_pkg.sv
// Shared encodings for the branch target buffer, its return stack and the invalidate sweep.
package bpu_btb_pkg;

    typedef enum logic [1:0] {
        BP_BRANCH = 2'd0,
        BP_JAL    = 2'd1,
        BP_CALL   = 2'd2,
        BP_RET    = 2'd3
    } bp_type_e;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/bpu_ras.sv
// Commit-time return address stack: circular buffer, oldest entry overwritten when full.
module bpu_ras
    import bpu_btb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW:0]       count;

    // ptr names the next free slot; it wraps naturally at RAS_DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_ONE;
            if (count != CNT_FULL)
                count <= count + CNT_ONE;
        end else if (pop && count != '0) begin
            ptr   <= ptr - PTR_ONE;
            count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            stack[ptr] <= push_data;
    end

    assign top   = stack[ptr - PTR_ONE];
    assign empty = (count == '0);

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit counters, commit-time RAS and a sequential invalidate sweep.
module bpu_btb
    import bpu_btb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ENTRIES   = 16,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic [1:0]        upd_type_i,
    input  logic              flush_i,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic              ent_valid [ENTRIES];
    logic [1:0]        ent_ctr   [ENTRIES];
    logic [TAG_W-1:0]  ent_tag   [ENTRIES];
    logic [1:0]        ent_type  [ENTRIES];
    logic [ADDR_W-1:0] ent_tgt   [ENTRIES];

    sweep_state_e     state;
    logic [IDX_W-1:0] sweep_idx;

    logic [IDX_W-1:0]  p_idx, u_idx;
    logic [TAG_W-1:0]  p_tag, u_tag;
    logic              upd_en, u_hit, u_alloc, upd_write;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^{pred_pc_i, upd_pc_i};

    assign p_idx = pred_pc_i[IDX_W+1:2];
    assign p_tag = pred_pc_i[TAG_W+IDX_W+1:IDX_W+2];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign u_tag = upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];

    // Lookup reads the table as it stands before this cycle's update lands
    assign pred_hit_o    = (state == ST_IDLE) && ent_valid[p_idx] && (ent_tag[p_idx] == p_tag);
    assign pred_taken_o  = pred_hit_o && ((ent_type[p_idx] != BP_BRANCH) || ent_ctr[p_idx][1]);
    assign pred_target_o = !pred_hit_o ? '0 :
                           ((ent_type[p_idx] == BP_RET) && !ras_empty) ? ras_top : ent_tgt[p_idx];
    assign busy_o        = (state == ST_SWEEP);

    assign upd_en    = upd_valid_i && (state == ST_IDLE);
    assign u_hit     = ent_valid[u_idx] && (ent_tag[u_idx] == u_tag);
    assign u_alloc   = !u_hit && (upd_taken_i || (upd_type_i != BP_BRANCH));
    assign upd_write = upd_en && (u_hit || u_alloc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i] <= 1'b0;
                ent_ctr[i]   <= CTR_WNT;
            end
        end else begin
            if (state == ST_SWEEP) begin
                ent_valid[sweep_idx] <= 1'b0;
            end else if (upd_write) begin
                ent_valid[u_idx] <= 1'b1;
                ent_ctr[u_idx]   <= !u_hit ? CTR_WT :
                                    upd_taken_i ? ctr_sat_inc(ent_ctr[u_idx]) : ctr_sat_dec(ent_ctr[u_idx]);
            end
            if (flush_i) begin
                state     <= ST_SWEEP;
                sweep_idx <= '0;
            end else if (state == ST_SWEEP) begin
                sweep_idx <= sweep_idx + IDX_ONE;
                if (sweep_idx == IDX_LAST)
                    state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_write) begin
            ent_tag[u_idx]  <= u_tag;
            ent_type[u_idx] <= upd_type_i;
            ent_tgt[u_idx]  <= upd_target_i;
        end
    end

    bpu_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (upd_en && (upd_type_i == BP_CALL)),
        .pop       (upd_en && (upd_type_i == BP_RET)),
        .push_data (upd_pc_i + ADDR_W'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule
